// File: rtl/instruction_decoder_pkg.sv
// ---------------------------------------------------------------------------
// instruction_decoder_pkg
//
// Shared types and constants for the instruction decoder front end.
//   - opcode_e     : 2-bit opcode carried in the top bits of every word
//   - state_e      : decoder FSM states
//   - OPCODE_MSB/LSB : location of the opcode field inside an instruction word
//   - decode_opcode(): maps a raw opcode field onto opcode_e
// ---------------------------------------------------------------------------
package instruction_decoder_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 30;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_MOVE = 2'b01,
        OP_IMM  = 2'b10,
        OP_RSVD = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_IMM_WAIT = 2'b01,
        S_MOVE_OUT = 2'b10,
        S_IMM_OUT  = 2'b11
    } state_e;

    // Every 2-bit pattern is a legal encoding, so the cast is total.
    function automatic opcode_e decode_opcode(input logic [1:0] field);
        return opcode_e'(field);
    endfunction

endpackage

// File: rtl/instruction_interface.sv
// ---------------------------------------------------------------------------
// instruction_interface
//
// Command channel between the instruction decoder (producer) and the
// interconnect scheduler (consumer). Two independent valid/ack channels:
//   move      : move_valid, move_from, move_to   -> producer ; move_ack <- consumer
//   immediate : immediate_valid, immediate_addr,
//               immediate                        -> producer ; immediate_ack <- consumer
// A transfer completes in any cycle where valid && ack on the same channel.
// ---------------------------------------------------------------------------
interface instruction_interface #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic                  move_valid;
    logic                  move_ack;
    logic [ADDR_WIDTH-1:0] move_from;
    logic [ADDR_WIDTH-1:0] move_to;

    logic                  immediate_valid;
    logic                  immediate_ack;
    logic [ADDR_WIDTH-1:0] immediate_addr;
    logic [DATA_WIDTH-1:0] immediate;

    modport producer (
        output move_valid,
        output move_from,
        output move_to,
        input  move_ack,
        output immediate_valid,
        output immediate_addr,
        output immediate,
        input  immediate_ack
    );

    modport consumer (
        input  move_valid,
        input  move_from,
        input  move_to,
        output move_ack,
        input  immediate_valid,
        input  immediate_addr,
        input  immediate,
        output immediate_ack
    );

endinterface

// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
//
// Turns a stream of 32-bit instruction words into move / immediate commands.
// Commands issue strictly in order with at most one outstanding; when the
// consumer acks immediately a new word is accepted in the ack cycle, so one
// command per cycle is sustained.
//
// Ports:
//   clk          : rising-edge clock
//   resetn       : asynchronous, active-low reset
//   in_data      : instruction word
//   in_valid     : in_data valid
//   in_ready     : word accepted when in_valid && in_ready
//   instr        : instruction_interface producer modport (move / immediate)
//   error        : sticky flag, set when a reserved opcode is consumed
//   issued_count : number of completed (acked) commands, wraps at 2^32
// ---------------------------------------------------------------------------
module instruction_decoder
    import instruction_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    instruction_interface.producer instr,
    output logic                  error,
    output logic [31:0]           issued_count
);

    state_e                state_q;
    state_e                state_d;

    logic [ADDR_WIDTH-1:0] move_from_q;
    logic [ADDR_WIDTH-1:0] move_to_q;
    logic [ADDR_WIDTH-1:0] imm_addr_q;
    logic [DATA_WIDTH-1:0] imm_data_q;
    logic                  error_q;
    logic [31:0]           count_q;

    logic                  move_done;
    logic                  imm_done;
    logic                  can_decode;
    logic                  accept;
    logic                  load_move;
    logic                  load_header;
    logic                  load_data;
    logic                  set_error;
    opcode_e               opcode;

    assign opcode    = decode_opcode(in_data[OPCODE_MSB:OPCODE_LSB]);
    assign move_done = (state_q == S_MOVE_OUT) && instr.move_ack;
    assign imm_done  = (state_q == S_IMM_OUT)  && instr.immediate_ack;

    // A new opcode may be decoded in IDLE or in the very cycle the pending
    // command completes; that is what gives back-to-back issue.
    assign can_decode = (state_q == S_IDLE) || move_done || imm_done;

    // Ready follows the matching ack combinationally while a command is
    // pending. It is also forced low during reset so no word is taken.
    always_comb begin
        in_ready = 1'b0;
        if (resetn) begin
            case (state_q)
                S_IDLE:     in_ready = 1'b1;
                S_IMM_WAIT: in_ready = 1'b1;
                S_MOVE_OUT: in_ready = instr.move_ack;
                S_IMM_OUT:  in_ready = instr.immediate_ack;
                default:    in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    // Next-state and load-enable decode.
    always_comb begin
        state_d     = state_q;
        load_move   = 1'b0;
        load_header = 1'b0;
        load_data   = 1'b0;
        set_error   = 1'b0;

        if (state_q == S_IMM_WAIT) begin
            // The word after an IMM header is pure data; its top bits are
            // not interpreted as an opcode.
            if (accept) begin
                state_d   = S_IMM_OUT;
                load_data = 1'b1;
            end
        end else if (can_decode) begin
            state_d = S_IDLE;
            if (accept) begin
                case (opcode)
                    OP_MOVE: begin
                        state_d   = S_MOVE_OUT;
                        load_move = 1'b1;
                    end
                    OP_IMM: begin
                        state_d     = S_IMM_WAIT;
                        load_header = 1'b1;
                    end
                    OP_RSVD: begin
                        set_error = 1'b1;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields. They only load on acceptance, so they stay stable
    // for as long as the matching valid is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            move_from_q <= '0;
            move_to_q   <= '0;
            imm_addr_q  <= '0;
            imm_data_q  <= '0;
        end else begin
            if (load_move) begin
                move_from_q <= in_data[ADDR_WIDTH-1:0];
                move_to_q   <= in_data[2*ADDR_WIDTH-1:ADDR_WIDTH];
            end
            if (load_header) begin
                imm_addr_q <= in_data[ADDR_WIDTH-1:0];
            end
            if (load_data) begin
                imm_data_q <= in_data[DATA_WIDTH-1:0];
            end
        end
    end

    // Sticky error flag and completed-command counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (set_error) begin
                error_q <= 1'b1;
            end
            if (move_done || imm_done) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign instr.move_valid      = (state_q == S_MOVE_OUT);
    assign instr.move_from       = move_from_q;
    assign instr.move_to         = move_to_q;
    assign instr.immediate_valid = (state_q == S_IMM_OUT);
    assign instr.immediate_addr  = imm_addr_q;
    assign instr.immediate       = imm_data_q;

    assign error        = error_q;
    assign issued_count = count_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_decoder
//
// Directed test of instruction_decoder. Inputs change and outputs are
// checked 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_decoder;

    logic        clk;
    logic        resetn;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        error;
    logic [31:0] issued_count;

    int compareCount;
    int mismatchCount;

    instruction_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) instr_if ();

    instruction_decoder #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .WORD_WIDTH(32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr_if),
        .error        (error),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    // Present one word for exactly one edge.
    task automatic applyStimulus(input logic [31:0] word);
        in_data  = word;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    initial begin
        compareCount           = 0;
        mismatchCount          = 0;
        resetn                 = 1'b0;
        in_data                = 32'h0;
        in_valid               = 1'b0;
        instr_if.move_ack      = 1'b0;
        instr_if.immediate_ack = 1'b0;

        // Reset values
        stepCycle();
        stepCycle();
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_move_valid", instr_if.move_valid, 0);
        checkOutput("rst_imm_valid", instr_if.immediate_valid, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_count", issued_count, 0);
        resetn = 1'b1;
        #1;
        checkOutput("idle_in_ready", in_ready, 1);

        // MOVE with ack tied high
        instr_if.move_ack = 1'b1;
        applyStimulus(32'h4000_0302);
        checkOutput("mv1_valid", instr_if.move_valid, 1);
        checkOutput("mv1_from", instr_if.move_from, 8'h02);
        checkOutput("mv1_to", instr_if.move_to, 8'h03);
        stepCycle();
        checkOutput("mv1_valid_drop", instr_if.move_valid, 0);
        checkOutput("mv1_count", issued_count, 1);
        instr_if.move_ack = 1'b0;

        // IMM header, 3 idle cycles, then data
        applyStimulus(32'h8000_0015);
        checkOutput("imm_wait_ready", in_ready, 1);
        checkOutput("imm_wait_valid", instr_if.immediate_valid, 0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("imm_gap_ready", in_ready, 1);
            checkOutput("imm_gap_valid", instr_if.immediate_valid, 0);
        end
        applyStimulus(32'hDEAD_BEEF);
        checkOutput("imm_valid", instr_if.immediate_valid, 1);
        checkOutput("imm_addr", instr_if.immediate_addr, 8'h15);
        checkOutput("imm_data", instr_if.immediate, 32'hDEAD_BEEF);
        checkOutput("imm_noack_ready", in_ready, 0);
        checkOutput("imm_no_move", instr_if.move_valid, 0);
        instr_if.immediate_ack = 1'b1;
        #1;
        checkOutput("imm_ack_ready", in_ready, 1);
        stepCycle();
        checkOutput("imm_valid_drop", instr_if.immediate_valid, 0);
        checkOutput("imm_count", issued_count, 2);
        instr_if.immediate_ack = 1'b0;

        // MOVE held for 5 cycles; wrong-channel ack must be ignored
        applyStimulus(32'h4000_0A0B);
        instr_if.immediate_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", instr_if.move_valid, 1);
            checkOutput("hold_from", instr_if.move_from, 8'h0B);
            checkOutput("hold_to", instr_if.move_to, 8'h0A);
            checkOutput("hold_ready", in_ready, 0);
            stepCycle();
        end
        instr_if.immediate_ack = 1'b0;
        checkOutput("hold_count", issued_count, 2);
        // Ack and the next MOVE in the same cycle
        instr_if.move_ack = 1'b1;
        in_data  = 32'h4000_0C0D;
        in_valid = 1'b1;
        #1;
        checkOutput("b2b_ready", in_ready, 1);
        stepCycle();
        in_valid = 1'b0;
        instr_if.move_ack = 1'b0;
        checkOutput("b2b_valid", instr_if.move_valid, 1);
        checkOutput("b2b_from", instr_if.move_from, 8'h0D);
        checkOutput("b2b_to", instr_if.move_to, 8'h0C);
        checkOutput("b2b_count", issued_count, 3);
        instr_if.move_ack = 1'b1;
        stepCycle();
        checkOutput("b2b_done_valid", instr_if.move_valid, 0);
        checkOutput("b2b_done_count", issued_count, 4);

        // Acks with no valid pending are ignored
        instr_if.immediate_ack = 1'b1;
        stepCycle();
        stepCycle();
        instr_if.immediate_ack = 1'b0;
        checkOutput("stray_ack_count", issued_count, 4);
        checkOutput("stray_ack_valid", instr_if.move_valid, 0);

        // NOP, reserved, MOVE (move_ack still high)
        applyStimulus(32'h0000_0000);
        checkOutput("nop_valid", instr_if.move_valid, 0);
        checkOutput("nop_error", error, 0);
        applyStimulus(32'hC000_0000);
        checkOutput("rsvd_error", error, 1);
        checkOutput("rsvd_valid", instr_if.move_valid, 0);
        applyStimulus(32'h4000_0201);
        checkOutput("err_mv_valid", instr_if.move_valid, 1);
        checkOutput("err_mv_from", instr_if.move_from, 8'h01);
        checkOutput("err_mv_to", instr_if.move_to, 8'h02);
        stepCycle();
        checkOutput("err_mv_count", issued_count, 5);
        checkOutput("err_sticky", error, 1);

        // Counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        applyStimulus(32'h4000_0000);
        checkOutput("wrap_valid", instr_if.move_valid, 1);
        stepCycle();
        checkOutput("wrap_count", issued_count, 0);
        instr_if.move_ack = 1'b0;

        // Reset while an IMM header is held
        applyStimulus(32'h8000_0042);
        checkOutput("rst_wait_ready_pre", in_ready, 1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_wait_ready", in_ready, 0);
        checkOutput("rst_wait_error", error, 0);
        checkOutput("rst_wait_addr", instr_if.immediate_addr, 0);
        stepCycle();
        resetn = 1'b1;
        applyStimulus(32'h4000_0504);
        checkOutput("post_rst_move", instr_if.move_valid, 1);
        checkOutput("post_rst_imm", instr_if.immediate_valid, 0);
        checkOutput("post_rst_from", instr_if.move_from, 8'h04);
        checkOutput("post_rst_to", instr_if.move_to, 8'h05);
        checkOutput("post_rst_count", issued_count, 0);
        instr_if.move_ack = 1'b1;
        stepCycle();
        instr_if.move_ack = 1'b0;
        checkOutput("post_rst_done", issued_count, 1);

        // Reset while immediate_valid is pending
        applyStimulus(32'h8000_0033);
        applyStimulus(32'h1234_5678);
        checkOutput("pend_imm_valid", instr_if.immediate_valid, 1);
        checkOutput("pend_imm_data", instr_if.immediate, 32'h1234_5678);
        resetn = 1'b0;
        #1;
        checkOutput("rst_pend_valid", instr_if.immediate_valid, 0);
        checkOutput("rst_pend_data", instr_if.immediate, 0);
        checkOutput("rst_pend_addr", instr_if.immediate_addr, 0);
        checkOutput("rst_pend_from", instr_if.move_from, 0);
        checkOutput("rst_pend_count", issued_count, 0);
        checkOutput("rst_pend_ready", in_ready, 0);
        stepCycle();
        resetn = 1'b1;
        instr_if.move_ack = 1'b1;
        applyStimulus(32'h4000_0706);
        checkOutput("after_pend_move", instr_if.move_valid, 1);
        checkOutput("after_pend_imm", instr_if.immediate_valid, 0);
        checkOutput("after_pend_from", instr_if.move_from, 8'h06);
        checkOutput("after_pend_to", instr_if.move_to, 8'h07);
        stepCycle();
        checkOutput("after_pend_count", issued_count, 1);
        instr_if.move_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
